// File: rtl/bird_pkg.sv
// Shared types and default constants for the bird sprite physics.
package bird_pkg;

  // Game-state encoding; values are visible on the game_state port.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFly  = 2'd1,
    StFall = 2'd2,
    StDead = 2'd3
  } bird_state_e;

  localparam int          CoordWDef  = 10;
  localparam int          VelWDef    = 6;
  localparam int          XStartDef  = 100;
  localparam int          YStartDef  = 240;
  localparam int          YMinDef    = 0;
  localparam int          YMaxDef    = 479;
  localparam int          SizeDef    = 16;
  localparam int          GravityDef = 1;
  localparam int          FlapVelDef = -6;
  localparam int          VmaxDef    = 8;
  localparam logic [7:0]  FlapKeyDef = 8'h1A;

  // Velocity plus increment, limited to the terminal (downward) velocity.
  function automatic int vel_sat_add(input int vel, input int inc, input int vmax);
    int sum;
    sum = vel + inc;
    return (sum > vmax) ? vmax : sum;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Single-frame pulse when a given keycode first appears.
module key_edge_detect
  import bird_pkg::*;
#(
  parameter logic [7:0] KEY = FlapKeyDef
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       pulse
);

  logic hit;
  logic hit_q;

  assign hit   = (keycode == KEY);
  assign pulse = hit & ~hit_q;

  // Remember whether the key was down last frame so a held key flaps once.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Vertical physics and game-state FSM for the player sprite. X is fixed.
module bird_physics
  import bird_pkg::*;
#(
  parameter int         COORD_W  = CoordWDef,
  parameter int         VEL_W    = VelWDef,
  parameter int         X_START  = XStartDef,
  parameter int         Y_START  = YStartDef,
  parameter int         Y_MIN    = YMinDef,
  parameter int         Y_MAX    = YMaxDef,
  parameter int         SIZE     = SizeDef,
  parameter int         GRAVITY  = GravityDef,
  parameter int         FLAP_VEL = FlapVelDef,
  parameter int         VMAX     = VmaxDef,
  parameter logic [7:0] FLAP_KEY = FlapKeyDef
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic               collide,
  output logic [COORD_W-1:0] BirdX,
  output logic [COORD_W-1:0] BirdY,
  output logic [COORD_W-1:0] BirdS,
  output logic [VEL_W-1:0]   BirdVel,
  output logic [1:0]         game_state,
  output logic               dead
);

  // Two guard bits keep y_n from wrapping before the clamps look at it.
  localparam int AW = COORD_W + 2;

  localparam logic signed [AW-1:0]    YFloorA = AW'(Y_MAX - SIZE);
  localparam logic signed [AW-1:0]    YMinA   = AW'(Y_MIN);
  localparam logic [COORD_W-1:0]      YStart  = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0]      YLaunch = COORD_W'(Y_START + FLAP_VEL);
  localparam logic [COORD_W-1:0]      YFloor  = COORD_W'(Y_MAX - SIZE);
  localparam logic [COORD_W-1:0]      YMin    = COORD_W'(Y_MIN);
  localparam logic signed [VEL_W-1:0] FlapVel = VEL_W'(FLAP_VEL);

  bird_state_e               state_q, state_d;
  logic [COORD_W-1:0]        y_q, y_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic                      dead_q;

  logic                      flap_edge;
  logic signed [VEL_W-1:0]   vel_grav, vel_n;
  logic signed [AW-1:0]      y_n;
  logic                      hit_floor, hit_ceil;

  key_edge_detect #(
    .KEY (FLAP_KEY)
  ) u_flap_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .pulse     (flap_edge)
  );

  // Semi-implicit step: new velocity first, then position from it.
  always_comb begin
    vel_grav  = VEL_W'(vel_sat_add(int'(vel_q), GRAVITY, VMAX));
    vel_n     = (state_q == StFly && flap_edge) ? FlapVel : vel_grav;
    y_n       = $signed({2'b00, y_q}) + AW'(vel_n);
    hit_floor = (y_n >= YFloorA);
    hit_ceil  = (y_n < YMinA);
  end

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    unique case (state_q)
      StIdle: begin
        if (flap_edge) begin
          state_d = StFly;
          y_d     = YLaunch;
          vel_d   = FlapVel;
        end
      end
      StFly, StFall: begin
        // A hit freezes the bird in place and wins over flap and clamps.
        if (state_q == StFly && collide) begin
          state_d = StFall;
          vel_d   = '0;
        end else if (hit_floor) begin
          state_d = StDead;
          y_d     = YFloor;
          vel_d   = '0;
        end else if (hit_ceil) begin
          y_d     = YMin;
          vel_d   = '0;
        end else begin
          y_d     = y_n[COORD_W-1:0];
          vel_d   = vel_n;
        end
      end
      StDead: begin
        // Restart only; this flap does not launch.
        if (flap_edge) begin
          state_d = StIdle;
          y_d     = YStart;
          vel_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset values appear without a clock edge.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      y_q     <= YStart;
      vel_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      dead_q  <= (state_d == StDead);
    end
  end

  assign BirdX      = COORD_W'(X_START);
  assign BirdS      = COORD_W'(SIZE);
  assign BirdY      = y_q;
  assign BirdVel    = vel_q;
  assign game_state = state_q;
  assign dead       = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics: vector table, corner sequences, random run.
module tb_bird_physics;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic       collide   = 1'b0;
  logic [9:0] BirdX, BirdY, BirdS;
  logic [5:0] BirdVel;
  logic [1:0] game_state;
  logic       dead;

  bird_physics dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .collide    (collide),
    .BirdX      (BirdX),
    .BirdY      (BirdY),
    .BirdS      (BirdS),
    .BirdVel    (BirdVel),
    .game_state (game_state),
    .dead       (dead)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: plain integers following the game rules.
  int m_st, m_y, m_vel;
  bit m_prev;

  typedef struct {
    logic [7:0] key;
    bit         col;
    int         y;
    int         vel;
    int         st;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input integer got, input integer exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = 240; m_vel = 0; m_prev = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] k, input bit c);
    bit fe;
    int v, yn;
    fe     = (k == 8'h1A) && !m_prev;
    m_prev = (k == 8'h1A);
    case (m_st)
      0: if (fe) begin m_st = 1; m_vel = -6; m_y = 234; end
      1, 2: begin
        if (m_st == 1 && c) begin
          m_vel = 0; m_st = 2;
        end else begin
          v  = (m_st == 1 && fe) ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
          yn = m_y + v;
          if (yn + 16 >= 479) begin
            m_y = 463; m_vel = 0; m_st = 3;
          end else if (yn < 0) begin
            m_y = 0; m_vel = 0;
          end else begin
            m_y = yn; m_vel = v;
          end
        end
      end
      default: if (fe) begin m_st = 0; m_y = 240; m_vel = 0; end
    endcase
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_y"},     BirdY, m_y);
    chk({nm, "_vel"},   $signed(BirdVel), m_vel);
    chk({nm, "_state"}, game_state, m_st);
    chk({nm, "_dead"},  dead, (m_st == 3) ? 1 : 0);
    chk({nm, "_x"},     BirdX, 100);
    chk({nm, "_s"},     BirdS, 16);
  endtask

  // Apply inputs for one frame, advance, and compare against the model.
  task automatic frame(input logic [7:0] k, input bit c, input string nm);
    keycode = k;
    collide = c;
    @(posedge frame_clk);
    model_step(k, c);
    #1;
    chk_model(nm);
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic async_reset(input string nm);
    @(negedge frame_clk);
    #1 Reset = 1'b1;
    model_reset();
    #1;
    chk({nm, "_y"},     BirdY, 240);
    chk({nm, "_vel"},   $signed(BirdVel), 0);
    chk({nm, "_state"}, game_state, 0);
    chk({nm, "_dead"},  dead, 0);
    chk({nm, "_x"},     BirdX, 100);
    chk({nm, "_s"},     BirdS, 16);
    #1 Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    async_reset("reset");

    // Flap from IDLE, hold, re-press, then free fall to terminal velocity,
    // then a hit together with a flap, then ignored flaps while falling.
    vecs.push_back('{8'h1A, 1'b0, 234, -6, 1});
    vecs.push_back('{8'h1A, 1'b0, 229, -5, 1});
    vecs.push_back('{8'h1A, 1'b0, 225, -4, 1});
    vecs.push_back('{8'h00, 1'b0, 222, -3, 1});
    vecs.push_back('{8'h1A, 1'b0, 216, -6, 1});
    vecs.push_back('{8'h00, 1'b0, 211, -5, 1});
    vecs.push_back('{8'h00, 1'b0, 207, -4, 1});
    vecs.push_back('{8'h00, 1'b0, 204, -3, 1});
    vecs.push_back('{8'h00, 1'b0, 202, -2, 1});
    vecs.push_back('{8'h00, 1'b0, 201, -1, 1});
    vecs.push_back('{8'h00, 1'b0, 201,  0, 1});
    vecs.push_back('{8'h00, 1'b0, 202,  1, 1});
    vecs.push_back('{8'h00, 1'b0, 204,  2, 1});
    vecs.push_back('{8'h00, 1'b0, 207,  3, 1});
    vecs.push_back('{8'h00, 1'b0, 211,  4, 1});
    vecs.push_back('{8'h00, 1'b0, 216,  5, 1});
    vecs.push_back('{8'h00, 1'b0, 222,  6, 1});
    vecs.push_back('{8'h00, 1'b0, 229,  7, 1});
    vecs.push_back('{8'h00, 1'b0, 237,  8, 1});
    vecs.push_back('{8'h00, 1'b0, 245,  8, 1});
    vecs.push_back('{8'h00, 1'b0, 253,  8, 1});
    vecs.push_back('{8'h1A, 1'b1, 253,  0, 2});
    vecs.push_back('{8'h00, 1'b0, 254,  1, 2});
    vecs.push_back('{8'h1A, 1'b0, 256,  2, 2});
    vecs.push_back('{8'h00, 1'b0, 259,  3, 2});

    foreach (vecs[i]) begin
      frame(vecs[i].key, vecs[i].col, "tbl_model");
      chk("tbl_y",     BirdY, vecs[i].y);
      chk("tbl_vel",   $signed(BirdVel), vecs[i].vel);
      chk("tbl_state", game_state, vecs[i].st);
    end

    // Keep falling with flaps and hits sprinkled in until the floor.
    for (int i = 0; i < 100 && m_st != 3; i++) begin
      frame((i % 2 == 0) ? 8'h1A : 8'h00, (i % 3 == 0), "fall");
    end
    chk("dead_state", game_state, 3);
    chk("dead_flag",  dead, 1);
    chk("dead_y",     BirdY, 463);
    frame(8'h00, 1'b0, "dead_hold");
    chk("dead_hold_y", BirdY, 463);
    frame(8'h1A, 1'b0, "restart");
    chk("restart_state", game_state, 0);
    chk("restart_y",     BirdY, 240);
    chk("restart_vel",   $signed(BirdVel), 0);
    chk("restart_dead",  dead, 0);

    // Climb with alternating flaps until the ceiling clamps.
    for (int i = 0; i < 100 && !(m_st == 1 && m_y == 0); i++) begin
      frame((i % 2 == 0) ? 8'h1A : 8'h00, 1'b0, "climb");
    end
    chk("ceil_y",     BirdY, 0);
    chk("ceil_vel",   $signed(BirdVel), 0);
    chk("ceil_state", game_state, 1);
    frame(8'h00, 1'b0, "after_ceil");
    chk("after_ceil_y",   BirdY, 1);
    chk("after_ceil_vel", $signed(BirdVel), 1);

    // Hit, fall for 7 frames, then reset asynchronously mid-fall.
    frame(8'h00, 1'b1, "hit");
    chk("hit_state", game_state, 2);
    for (int i = 0; i < 7; i++) frame(8'h00, 1'b0, "fall7");
    chk("fall7_vel", $signed(BirdVel), 7);
    chk("fall7_state", game_state, 2);
    async_reset("midfall_reset");
    for (int i = 0; i < 4; i++) begin
      frame(8'h00, 1'b0, "static");
      chk("static_y",     BirdY, 240);
      chk("static_state", game_state, 0);
    end

    // Randomised play checked frame by frame against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] k;
      bit         c;
      k = ($urandom_range(0, 2) == 0) ? 8'h1A : 8'($urandom);
      c = ($urandom_range(0, 29) == 0);
      frame(k, c, "rand");
      if (i % 500 == 499) async_reset("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Vertical-physics engine for the player sprite. It is the parametrised successor to the keyboard-driven ball mover.
- Applies gravity, a flap impulse and a terminal velocity once per frame, and clamps the sprite at the ceiling and floor.
- Runs a game-state FSM (idle, flying, falling after a hit, dead). Sits between the USB keycode path and the colour mapper and collision logic.
- X position is fixed; only Y moves.

Parameters:
- COORD_W, 10, width of all screen coordinates.
- VEL_W, 6, width of signed velocity (two's complement).
- X_START, 100, fixed sprite X (left edge).
- Y_START, 240, sprite Y (top edge) in IDLE and after restart.
- Y_MIN, 0, topmost legal sprite Y.
- Y_MAX, 479, bottom screen row; the floor contact row.
- SIZE, 16, sprite edge length in pixels.
- GRAVITY, 1, velocity increment per frame (positive means downward).
- FLAP_VEL, -6, velocity loaded on a flap (signed).
- VMAX, 8, terminal downward velocity.
- FLAP_KEY, 8'h1A, keycode that flaps (W).

Ports:
- frame_clk  in  1  frame-rate clock (vsync); one update per rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current USB keycode.
- collide  in  1  pipe-hit flag from collision logic, sampled each frame.
- BirdX  out  COORD_W  sprite X; constant X_START.
- BirdY  out  COORD_W  sprite Y (top edge).
- BirdS  out  COORD_W  sprite size; constant SIZE.
- BirdVel  out  VEL_W  current signed velocity.
- game_state  out  2  0 IDLE, 1 FLY, 2 FALL, 3 DEAD.
- dead  out  1  high while game_state is DEAD.

Behaviour:
- Reset is asynchronous and active-high; clock is frame_clk. While Reset is asserted:
  - BirdY=Y_START, BirdVel=0, game_state=IDLE, dead=0.
  - The key-edge register is cleared.
  - Outputs take these values immediately, without waiting for a clock edge.
- flap_edge is a single-frame pulse: keycode==FLAP_KEY this frame and !=FLAP_KEY on the previous frame. Holding the key produces exactly one flap.
- Integration order (semi-implicit): first compute vel_n, then y_n = BirdY + vel_n. A flap therefore moves the sprite on the same frame it is detected, which removes the one-frame motion lag of the old mover.
- Arithmetic is done in signed COORD_W+2 bits, so y_n never wraps before the clamps are applied.
- IDLE:
  - Hold Y_START and vel 0.
  - On flap_edge: vel=FLAP_VEL, Y=Y_START+FLAP_VEL, go to FLY.
- FLY:
  - vel_n = FLAP_VEL if flap_edge; otherwise min(vel+GRAVITY, VMAX).
  - Ceiling: if y_n < Y_MIN, then Y=Y_MIN and vel=0; stay in FLY.
  - Floor: if y_n+SIZE >= Y_MAX, then Y=Y_MAX-SIZE and vel=0; go to DEAD.
  - If collide=1: vel=0, Y unchanged, go to FALL. collide takes priority over flap_edge and over both clamps in the same frame.
- FALL:
  - flap_edge and collide are ignored.
  - vel_n = min(vel+GRAVITY, VMAX) and Y updates as above.
  - Floor contact clamps Y to Y_MAX-SIZE, sets vel=0 and goes to DEAD. The ceiling clamp still applies.
- DEAD:
  - Hold Y and vel 0; dead=1.
  - On flap_edge: go to IDLE with Y=Y_START and vel=0. This is a restart; the flap does not launch.
- Latency:
  - All outputs are registered.
  - A key pressed before frame edge N is reflected in the outputs after edge N.
- dead is decoded from the state register and is glitch-free.

Decomposition:
- Package bird_pkg holds:
  - The state enum (IDLE, FLY, FALL, DEAD; 2 bits).
  - Default constants for the physics parameters and FLAP_KEY.
  - A saturating-add helper function for the velocity.
- Sub-module key_edge_detect (params KEY; ports frame_clk, Reset, keycode, pulse): registered compare plus rising-edge pulse, reused later for the pause key.
- bird_physics holds the FSM and the datapath.

Test Plan:
- Reset check: pulse Reset between clock edges, with no clock edge → BirdY=240, BirdX=100, BirdS=16, BirdVel=0, game_state=0, dead=0 immediately.
- Flap from IDLE: keycode=8'h1A held 3 frames → one flap only. Frame 1: Y=234, vel=-6, FLY. Frame 2: Y=229, vel=-5. Frame 3: Y=225, vel=-4. Release then re-press on frame 5 → vel=-6 again.
- Terminal velocity: in FLY with vel=0 and no keys → vel goes 1..8 over 8 frames, then stays 8; Y increases by 8 per frame after that.
- Ceiling clamp: in FLY with Y=3, vel=-5, flap_edge → Y=0, vel=0, still FLY. Next frame → vel=1, Y=1.
- Collision and death: collide=1 together with a flap in FLY at Y=200 → FALL, vel=0, Y=200. Flaps during FALL are ignored. Sprite reaches Y=463 → DEAD, dead=1. Next flap → IDLE, Y=240.
- Reset mid-fall: assert Reset asynchronously while in FALL with vel=7 → immediately IDLE, Y=240, vel=0. After deassertion with no keys → outputs stay static.
